// File: rtl/sram_mem_controller.sv
// Moves 32-bit MEM-stage loads/stores to a 16-bit asynchronous SRAM as two half-word phases
// (low half, then high half); ready stays low while an access is in flight.
module sram_mem_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        address,
    input  logic [31:0]        ST_val,
    output logic [31:0]        mem_out,
    output logic               ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [15:0]        SRAM_DQ_out,
    output logic               SRAM_DQ_oe,
    input  logic [15:0]        SRAM_DQ_in,
    output logic               SRAM_WE_N
);

    localparam int unsigned      CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_wr, w_wr_nxt;
    logic [SRAM_AW-1:0] r_lo, w_lo_nxt;
    logic [15:0]        r_st_hi, w_st_hi_nxt;
    logic [31:0]        r_mem, w_mem_nxt;
    logic [SRAM_AW-1:0] r_addr, w_addr_nxt;
    logic [15:0]        r_dq, w_dq_nxt;
    logic               r_oe, w_oe_nxt;
    logic               r_we_n, w_we_n_nxt;

    logic               w_req;
    logic               w_last;
    logic [31:0]        w_off;
    logic [SRAM_AW-1:0] w_lo;

    assign w_req  = MEM_R_EN | MEM_W_EN;
    assign w_last = (r_cnt == CNT_LAST);
    // Half-word index of the word's low half; off[1:0] is dropped, result wraps to SRAM_AW bits.
    assign w_off  = address - 32'(BASE_ADDR);
    assign w_lo   = SRAM_AW'((w_off >> 1) & 32'hFFFF_FFFE);

    assign ready       = (r_state == S_DONE) | ((r_state == S_IDLE) & ~w_req);
    assign mem_out     = r_mem;
    assign SRAM_ADDR   = r_addr;
    assign SRAM_DQ_out = r_dq;
    assign SRAM_DQ_oe  = r_oe;
    assign SRAM_WE_N   = r_we_n;

    // Pin values are computed for the state being entered, so they line up with that state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wr_nxt    = r_wr;
        w_lo_nxt    = r_lo;
        w_st_hi_nxt = r_st_hi;
        w_mem_nxt   = r_mem;
        w_addr_nxt  = r_addr;
        w_dq_nxt    = r_dq;
        w_oe_nxt    = 1'b0;
        w_we_n_nxt  = 1'b1;

        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = '0;
                    w_wr_nxt    = MEM_W_EN;
                    w_lo_nxt    = w_lo;
                    w_st_hi_nxt = ST_val[31:16];
                    w_addr_nxt  = w_lo;
                    if (MEM_W_EN) begin
                        w_dq_nxt   = ST_val[15:0];
                        w_oe_nxt   = 1'b1;
                        w_we_n_nxt = 1'b0;
                    end
                end
            end
            S_LOW: begin
                w_oe_nxt   = r_wr;
                w_we_n_nxt = ~r_wr;
                if (w_last) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = '0;
                    w_addr_nxt  = r_lo | SRAM_AW'(1);
                    if (r_wr) begin
                        w_dq_nxt = r_st_hi;
                    end else begin
                        w_mem_nxt[15:0] = SRAM_DQ_in;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                    if (!r_wr) begin
                        w_mem_nxt[31:16] = SRAM_DQ_in;
                    end
                end else begin
                    w_cnt_nxt  = r_cnt + CNT_W'(1);
                    w_oe_nxt   = r_wr;
                    w_we_n_nxt = ~r_wr;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_lo    <= '0;
            r_st_hi <= '0;
            r_mem   <= '0;
            r_addr  <= '0;
            r_dq    <= '0;
            r_oe    <= 1'b0;
            r_we_n  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wr    <= w_wr_nxt;
            r_lo    <= w_lo_nxt;
            r_st_hi <= w_st_hi_nxt;
            r_mem   <= w_mem_nxt;
            r_addr  <= w_addr_nxt;
            r_dq    <= w_dq_nxt;
            r_oe    <= w_oe_nxt;
            r_we_n  <= w_we_n_nxt;
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller: default instance against an SRAM model,
// plus a WAIT_CYCLES=1 instance for the short-latency case.
module tb_sram_mem_controller;

    logic        clk;
    logic        rst;

    logic        r_en, w_en;
    logic [31:0] addr, st_val;
    logic [31:0] mem_out;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    logic        r_en1;
    logic [31:0] addr1;
    logic [31:0] st_val1;
    logic [31:0] mem_out1;
    logic        ready1;
    logic [17:0] sram_addr1;
    logic [15:0] sram_dq_out1;
    logic        sram_dq_oe1;
    logic [15:0] sram_dq_in1;
    logic        sram_we_n1;

    int errors = 0;
    int checks = 0;

    logic [15:0] sram [0:(1<<18)-1];

    sram_mem_controller dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (r_en),
        .MEM_W_EN   (w_en),
        .address    (addr),
        .ST_val     (st_val),
        .mem_out    (mem_out),
        .ready      (ready),
        .SRAM_ADDR  (sram_addr),
        .SRAM_DQ_out(sram_dq_out),
        .SRAM_DQ_oe (sram_dq_oe),
        .SRAM_DQ_in (sram_dq_in),
        .SRAM_WE_N  (sram_we_n)
    );

    sram_mem_controller #(.WAIT_CYCLES(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (r_en1),
        .MEM_W_EN   (1'b0),
        .address    (addr1),
        .ST_val     (st_val1),
        .mem_out    (mem_out1),
        .ready      (ready1),
        .SRAM_ADDR  (sram_addr1),
        .SRAM_DQ_out(sram_dq_out1),
        .SRAM_DQ_oe (sram_dq_oe1),
        .SRAM_DQ_in (sram_dq_in1),
        .SRAM_WE_N  (sram_we_n1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM model: combinational read, write committed while WE_N is low.
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;
    end
    assign sram_dq_in = sram[sram_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Store from IDLE through DONE, then drop the request; lo/hi and data halves hand-computed.
    task automatic run_store(input string tag, input logic both, input logic [31:0] a,
                             input logic [31:0] d, input logic [17:0] lo, input logic [17:0] hi,
                             input logic [31:0] mem_keep);
        addr = a; st_val = d; w_en = 1'b1; r_en = both;
        #1;
        check({tag, " ready idle"}, 32'(ready), 32'd0);
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 2; c++) begin
                tick();
                check({tag, " addr"},  32'(sram_addr), (ph == 0) ? 32'(lo) : 32'(hi));
                check({tag, " dq"},    32'(sram_dq_out), (ph == 0) ? 32'(d[15:0]) : 32'(d[31:16]));
                check({tag, " we_n"},  32'(sram_we_n), 32'd0);
                check({tag, " oe"},    32'(sram_dq_oe), 32'd1);
                check({tag, " ready"}, 32'(ready), 32'd0);
            end
        end
        tick();
        check({tag, " done ready"}, 32'(ready), 32'd1);
        check({tag, " done we_n"},  32'(sram_we_n), 32'd1);
        check({tag, " done oe"},    32'(sram_dq_oe), 32'd0);
        check({tag, " mem_out"},    mem_out, mem_keep);
        tick();
        w_en = 1'b0; r_en = 1'b0;
        #1;
        check({tag, " idle ready"}, 32'(ready), 32'd1);
    endtask

    // Load from IDLE through DONE; hold=1 leaves the request asserted in DONE.
    task automatic run_load(input string tag, input logic [31:0] a, input logic [17:0] lo,
                            input logic [17:0] hi, input logic [31:0] exp_data, input logic hold);
        addr = a; r_en = 1'b1; w_en = 1'b0;
        #1;
        check({tag, " ready idle"}, 32'(ready), 32'd0);
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 2; c++) begin
                tick();
                check({tag, " addr"},  32'(sram_addr), (ph == 0) ? 32'(lo) : 32'(hi));
                check({tag, " we_n"},  32'(sram_we_n), 32'd1);
                check({tag, " oe"},    32'(sram_dq_oe), 32'd0);
                check({tag, " ready"}, 32'(ready), 32'd0);
            end
        end
        tick();
        check({tag, " done ready"}, 32'(ready), 32'd1);
        check({tag, " mem_out"},    mem_out, exp_data);
        check({tag, " done we_n"},  32'(sram_we_n), 32'd1);
        if (!hold) begin
            tick();
            r_en = 1'b0;
            #1;
            check({tag, " idle ready"}, 32'(ready), 32'd1);
        end
    endtask

    initial begin
        rst = 1'b0;
        r_en = 1'b0; w_en = 1'b0; addr = '0; st_val = '0;
        r_en1 = 1'b0; addr1 = '0; st_val1 = '0; sram_dq_in1 = 16'hA5A5;
        #12;
        check("reset we_n",    32'(sram_we_n), 32'd1);
        check("reset oe",      32'(sram_dq_oe), 32'd0);
        check("reset addr",    32'(sram_addr), 32'd0);
        check("reset dq",      32'(sram_dq_out), 32'd0);
        check("reset mem_out", mem_out, 32'd0);
        check("reset ready",   32'(ready), 32'd1);
        rst = 1'b1;
        tick();

        // Store 0xDEADBEEF at 1032 -> half-words 4 and 5.
        run_store("st1032", 1'b0, 32'd1032, 32'hDEAD_BEEF, 18'd4, 18'd5, 32'd0);
        check("sram[4]", 32'(sram[4]), 32'h0000_BEEF);
        check("sram[5]", 32'(sram[5]), 32'h0000_DEAD);

        run_load("ld1032", 32'd1032, 18'd4, 18'd5, 32'hDEAD_BEEF, 1'b0);

        // Read+write together is a store and leaves mem_out alone.
        run_store("rw1024", 1'b1, 32'd1024, 32'h1234_5678, 18'd0, 18'd1, 32'hDEAD_BEEF);
        check("sram[0]", 32'(sram[0]), 32'h0000_5678);
        check("sram[1]", 32'(sram[1]), 32'h0000_1234);
        check("rw mem_out kept", mem_out, 32'hDEAD_BEEF);

        // Address below BASE_ADDR wraps: 1020-1024 = -4 -> half-words 0x3FFFE/0x3FFFF.
        run_store("st1020", 1'b0, 32'd1020, 32'hCAFE_F00D, 18'h3FFFE, 18'h3FFFF, 32'hDEAD_BEEF);
        run_load("ld1020", 32'd1020, 18'h3FFFE, 18'h3FFFF, 32'hCAFE_F00D, 1'b0);

        // Back-to-back loads with the request held across DONE.
        run_load("b2b first", 32'd1032, 18'd4, 18'd5, 32'hDEAD_BEEF, 1'b1);
        tick();
        check("b2b idle ready", 32'(ready), 32'd0);
        check("b2b no restart addr", 32'(sram_addr), 32'd5);
        run_load("b2b second", 32'd1024, 18'd0, 18'd1, 32'h1234_5678, 1'b0);

        // WAIT_CYCLES=1: ready low for 3 cycles per access.
        r_en1 = 1'b1; addr1 = 32'd1032;
        #1;
        check("w1 ready idle", 32'(ready1), 32'd0);
        tick();
        check("w1 lo addr",  32'(sram_addr1), 32'd4);
        check("w1 lo ready", 32'(ready1), 32'd0);
        tick();
        check("w1 hi addr",  32'(sram_addr1), 32'd5);
        check("w1 hi ready", 32'(ready1), 32'd0);
        tick();
        check("w1 done ready", 32'(ready1), 32'd1);
        check("w1 mem_out",    mem_out1, 32'hA5A5_A5A5);
        check("w1 we_n",       32'(sram_we_n1), 32'd1);
        check("w1 oe",         32'(sram_dq_oe1), 32'd0);
        tick();
        addr1 = 32'd1024; sram_dq_in1 = 16'h5A5A;
        #1;
        check("w1 b2b idle ready", 32'(ready1), 32'd0);
        check("w1 b2b idle addr",  32'(sram_addr1), 32'd5);
        tick();
        check("w1 b2b lo addr",  32'(sram_addr1), 32'd0);
        check("w1 b2b lo ready", 32'(ready1), 32'd0);
        tick();
        check("w1 b2b hi addr",  32'(sram_addr1), 32'd1);
        check("w1 b2b hi ready", 32'(ready1), 32'd0);
        tick();
        check("w1 b2b done ready", 32'(ready1), 32'd1);
        check("w1 b2b mem_out",    mem_out1, 32'h5A5A_5A5A);
        tick();
        r_en1 = 1'b0;
        #1;
        check("w1 final ready", 32'(ready1), 32'd1);

        // Asynchronous reset during HIGH cnt=1 of a store.
        addr = 32'd1040; st_val = 32'hAAAA_5555; w_en = 1'b1;
        tick(); tick(); tick(); tick();
        check("pre-rst we_n", 32'(sram_we_n), 32'd0);
        check("pre-rst addr", 32'(sram_addr), 32'd9);
        #2;
        rst = 1'b0;
        #1;
        check("async rst we_n",    32'(sram_we_n), 32'd1);
        check("async rst oe",      32'(sram_dq_oe), 32'd0);
        check("async rst addr",    32'(sram_addr), 32'd0);
        check("async rst mem_out", mem_out, 32'd0);
        w_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("post-rst ready", 32'(ready), 32'd1);
        check("post-rst we_n",  32'(sram_we_n), 32'd1);
        check("post-rst oe",    32'(sram_dq_oe), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
